hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/lc3b_types.sv | 31 +++
 rtl/lu_detect.sv | 22 ++
 rtl/hazard_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// lc3b_types: shared types for the LC-3b pipeline hazard controller.
// Register/word types, hazard FSM states and the forwarding hold-register layout.
package lc3b_types;

   typedef logic [2:0]  lc3b_reg;
   typedef logic [15:0] lc3b_word;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DWAIT = 2'd1,
      IWAIT = 2'd2,
      LUBUB = 2'd3
   } hazard_state_t;

   // hold register: {valid[19], dest[18:16], data[15:0]}
   localparam int HOLD_W      = 20;
   localparam int HOLD_VLD    = 19;
   localparam int HOLD_DST_HI = 18;
   localparam int HOLD_DST_LO = 16;
   localparam int HOLD_DAT_HI = 15;

   typedef struct packed {
      logic     valid;
      lc3b_reg  dest;
      lc3b_word data;
   } hold_t;

   localparam int              CNT_W   = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/lu_detect.sv
// lu_detect: load-use comparator between the ID/EX load and IF/ID sources.
// Ports: i_is_load, i_dest, i_src1/2, i_use1/2 in; o_hazard out.
module lu_detect
   import lc3b_types::*;
(
   input  logic    i_is_load,
   input  lc3b_reg i_dest,
   input  lc3b_reg i_src1,
   input  lc3b_reg i_src2,
   input  logic    i_use1,
   input  logic    i_use2,
   output logic    o_hazard
);

   logic w_hit1;
   logic w_hit2;

   assign w_hit1   = i_use1 && (i_src1 == i_dest);
   assign w_hit2   = i_use2 && (i_src2 == i_dest);
   assign o_hazard = i_is_load && (w_hit1 || w_hit2);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/bubble/flush control for the LC-3b core.
// In: clk, rst_n, cache handshakes, load-use operands, MEM/WB writeback, br_taken.
// Out: load_* enables, bubble_idex, flush, hold_reg_out, stall_cnt.
module hazard_ctrl
   import lc3b_types::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              icache_resp,
   input  logic              dcache_req,
   input  logic              dcache_resp,
   input  logic              idex_is_load,
   input  lc3b_reg           idex_dest,
   input  lc3b_reg           ifid_src1,
   input  lc3b_reg           ifid_src2,
   input  logic              ifid_use1,
   input  logic              ifid_use2,
   input  logic              mewb_ld_dest,
   input  lc3b_reg           mewb_dest,
   input  lc3b_word          mewb_data,
   input  logic              br_taken,
   output logic              load_pc,
   output logic              load_ifid,
   output logic              load_idex,
   output logic              load_exme,
   output logic              load_mewb,
   output logic              bubble_idex,
   output logic              flush,
   output logic [HOLD_W-1:0] hold_reg_out,
   output logic [CNT_W-1:0]  stall_cnt
);

   hazard_state_t    r_state;
   hazard_state_t    w_next;
   hold_t            r_hold;
   logic [CNT_W-1:0] r_cnt;

   logic w_lu;
   logic w_dstall;
   logic w_front;
   logic w_back;

   lu_detect u_lu (
      .i_is_load (idex_is_load),
      .i_dest    (idex_dest),
      .i_src1    (ifid_src1),
      .i_src2    (ifid_src2),
      .i_use1    (ifid_use1),
      .i_use2    (ifid_use2),
      .o_hazard  (w_lu)
   );

   // Once waiting on the dcache only the response matters.
   assign w_dstall = (r_state == DWAIT) ? !dcache_resp
                                        : (dcache_req && !dcache_resp);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= RUN;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = RUN;
      unique case (r_state)
         RUN: begin
            if (w_dstall)              w_next = DWAIT;
            else if (!icache_resp)     w_next = IWAIT;
            else if (w_lu && !br_taken) w_next = LUBUB;
            else                       w_next = RUN;
         end
         DWAIT: w_next = dcache_resp ? RUN : DWAIT;
         IWAIT: begin
            if (w_dstall)          w_next = DWAIT;
            else if (!icache_resp) w_next = IWAIT;
            else                   w_next = RUN;
         end
         LUBUB: w_next = RUN;
         default: w_next = RUN;
      endcase
   end

   // A taken branch squashes the dependent instruction, so the
   // load-use stall is dropped entirely when br_taken is high.
   always_comb begin
      w_front     = 1'b1;
      w_back      = 1'b1;
      bubble_idex = 1'b0;
      flush       = 1'b0;
      if (w_dstall) begin
         w_front = 1'b0;
         w_back  = 1'b0;
      end else if (r_state == DWAIT) begin
         flush = br_taken;
      end else if (!icache_resp) begin
         w_front     = 1'b0;
         bubble_idex = 1'b1;
         flush       = br_taken;
      end else if (r_state == RUN && w_lu && !br_taken) begin
         w_front     = 1'b0;
         bubble_idex = 1'b1;
      end else begin
         flush = br_taken;
      end
   end

   assign load_pc   = w_front;
   assign load_ifid = w_front;
   assign load_idex = w_back;
   assign load_exme = w_back;
   assign load_mewb = w_back;

   // Writeback captured while ID/EX is frozen so it can still be forwarded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold <= '0;
      end else if (!w_back) begin
         if (mewb_ld_dest) r_hold <= {1'b1, mewb_dest, mewb_data};
      end else begin
         r_hold.valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          r_cnt <= '0;
      else if (!w_front && r_cnt != CNT_MAX) r_cnt <= r_cnt + 16'd1;
   end

   assign hold_reg_out = r_hold;
   assign stall_cnt    = r_cnt;

endmodule
